// File: rtl/rob_multi_wb.sv
// Reorder buffer: in-order tag allocation at the tail, multi-port write-back with
// operand forwarding, and one-per-cycle head retirement with store handshake and flush.
module rob_multi_wb #(
    parameter int DEPTH    = 16,
    parameter int TAG_W    = 4,
    parameter int XLEN     = 32,
    parameter int WB_PORTS = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      alloc_valid,
    input  logic [1:0]                alloc_type,
    input  logic [4:0]                alloc_rd,
    output logic                      alloc_ready,
    output logic [TAG_W-1:0]          alloc_tag,
    input  logic [TAG_W-1:0]          q1_tag,
    input  logic [TAG_W-1:0]          q2_tag,
    output logic                      q1_ready,
    output logic                      q2_ready,
    output logic [XLEN-1:0]           q1_value,
    output logic [XLEN-1:0]           q2_value,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
    input  logic [WB_PORTS*XLEN-1:0]  wb_value,
    input  logic [WB_PORTS*XLEN-1:0]  wb_target,
    input  logic [WB_PORTS-1:0]       wb_mispredict,
    output logic                      commit_valid,
    output logic [4:0]                commit_rd,
    output logic [XLEN-1:0]           commit_value,
    output logic [TAG_W-1:0]          commit_tag,
    output logic                      st_commit_valid,
    output logic [TAG_W-1:0]          st_commit_tag,
    input  logic                      st_commit_ack,
    output logic                      flush_valid,
    output logic [XLEN-1:0]           flush_pc,
    output logic                      rob_empty,
    output logic [TAG_W:0]            rob_count
);
    // Handshakes: an entry is allocated on an edge with rdy_in && alloc_valid && alloc_ready;
    // st_commit_valid stays high until the edge that samples st_commit_ack with rdy_in high.
    localparam logic [1:0] T_STORE = 2'd1;

    typedef enum logic {S_IDLE, S_ST_WAIT} head_state_t;

    head_state_t       state_q, state_d;
    logic [TAG_W-1:0]  head_q, tail_q;
    logic [TAG_W:0]    count_q;
    logic [DEPTH-1:0]  busy_q, ready_q, misp_q;
    logic [1:0]        type_q   [DEPTH];
    logic [4:0]        rd_q     [DEPTH];
    logic [XLEN-1:0]   value_q  [DEPTH];
    logic [XLEN-1:0]   target_q [DEPTH];

    logic              head_hit, retire, do_commit, do_flush, do_alloc;
    logic [XLEN-1:0]   q1_fwd, q2_fwd;

    assign alloc_ready     = (count_q < (TAG_W+1)'(DEPTH));
    assign alloc_tag       = tail_q;
    assign rob_count       = count_q;
    assign rob_empty       = (count_q == '0);
    assign st_commit_valid = (state_q == S_ST_WAIT);
    assign head_hit        = busy_q[head_q] && ready_q[head_q];

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        do_commit = 1'b0;
        do_flush  = 1'b0;
        if (rdy_in) begin
            case (state_q)
                S_IDLE: begin
                    if (head_hit) begin
                        if (type_q[head_q] == T_STORE) begin
                            state_d = S_ST_WAIT;
                        end else begin
                            do_commit = 1'b1;
                            retire    = 1'b1;
                            // BRANCH and JALR both have type bit 1 set.
                            do_flush  = type_q[head_q][1] && misp_q[head_q];
                        end
                    end
                end
                S_ST_WAIT: begin
                    if (st_commit_ack) begin
                        retire  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        do_alloc = rdy_in && alloc_valid && alloc_ready && !do_flush;
    end

    // Lowest-numbered matching port is applied last so it wins.
    always_comb begin
        q1_ready = ready_q[q1_tag];
        q1_fwd   = value_q[q1_tag];
        q2_ready = ready_q[q2_tag];
        q2_fwd   = value_q[q2_tag];
        for (int k = WB_PORTS - 1; k >= 0; k--) begin
            if (wb_valid[k] && wb_tag[k*TAG_W +: TAG_W] == q1_tag) begin
                q1_ready = 1'b1;
                q1_fwd   = wb_value[k*XLEN +: XLEN];
            end
            if (wb_valid[k] && wb_tag[k*TAG_W +: TAG_W] == q2_tag) begin
                q2_ready = 1'b1;
                q2_fwd   = wb_value[k*XLEN +: XLEN];
            end
        end
        q1_value = q1_ready ? q1_fwd : '0;
        q2_value = q2_ready ? q2_fwd : '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            busy_q        <= '0;
            ready_q       <= '0;
            commit_valid  <= 1'b0;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_tag    <= '0;
            st_commit_tag <= '0;
            flush_valid   <= 1'b0;
            flush_pc      <= '0;
        end else if (!rdy_in) begin
            commit_valid <= 1'b0;
            flush_valid  <= 1'b0;
        end else begin
            commit_valid <= do_commit;
            flush_valid  <= do_flush;
            if (do_commit) begin
                commit_rd    <= rd_q[head_q];
                commit_value <= value_q[head_q];
                commit_tag   <= head_q;
            end
            if (do_flush) flush_pc <= target_q[head_q];
            if (state_q == S_IDLE && state_d == S_ST_WAIT) st_commit_tag <= head_q;
            if (do_flush) begin
                busy_q  <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                for (int k = WB_PORTS - 1; k >= 0; k--) begin
                    if (wb_valid[k] && busy_q[wb_tag[k*TAG_W +: TAG_W]])
                        ready_q[wb_tag[k*TAG_W +: TAG_W]] <= 1'b1;
                end
                if (do_alloc) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    tail_q          <= tail_q + TAG_W'(1);
                end
                if (retire) begin
                    busy_q[head_q] <= 1'b0;
                    head_q         <= head_q + TAG_W'(1);
                end
                count_q <= count_q + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(retire);
            end
        end
    end

    // Payload storage needs no reset; only busy/ready qualify it.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !do_flush) begin
            for (int k = WB_PORTS - 1; k >= 0; k--) begin
                if (wb_valid[k] && busy_q[wb_tag[k*TAG_W +: TAG_W]]) begin
                    value_q[wb_tag[k*TAG_W +: TAG_W]]  <= wb_value[k*XLEN +: XLEN];
                    target_q[wb_tag[k*TAG_W +: TAG_W]] <= wb_target[k*XLEN +: XLEN];
                    misp_q[wb_tag[k*TAG_W +: TAG_W]]   <= wb_mispredict[k];
                end
            end
            if (do_alloc) begin
                type_q[tail_q] <= alloc_type;
                rd_q[tail_q]   <= alloc_rd;
            end
        end
    end
endmodule

// File: tb/tb_rob_multi_wb.sv
// Bench for rob_multi_wb: directed scenarios plus random traffic, all outputs
// compared every cycle against a behavioural reorder-buffer model.
module tb_rob_multi_wb;
  localparam int DEPTH = 16;
  localparam int TAG_W = 4;
  localparam int XLEN  = 32;
  localparam int P     = 2;

  logic             clk_in, rst_in, rdy_in;
  logic             alloc_valid, alloc_ready;
  logic [1:0]       alloc_type;
  logic [4:0]       alloc_rd;
  logic [TAG_W-1:0] alloc_tag, q1_tag, q2_tag;
  logic             q1_ready, q2_ready;
  logic [XLEN-1:0]  q1_value, q2_value;
  logic [P-1:0]       wb_valid, wb_mispredict;
  logic [P*TAG_W-1:0] wb_tag;
  logic [P*XLEN-1:0]  wb_value, wb_target;
  logic             commit_valid;
  logic [4:0]       commit_rd;
  logic [XLEN-1:0]  commit_value, flush_pc;
  logic [TAG_W-1:0] commit_tag, st_commit_tag;
  logic             st_commit_valid, st_commit_ack, flush_valid, rob_empty;
  logic [TAG_W:0]   rob_count;

  rob_multi_wb #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .WB_PORTS(P)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_target(wb_target), .wb_mispredict(wb_mispredict),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_tag(commit_tag), .st_commit_valid(st_commit_valid),
    .st_commit_tag(st_commit_tag), .st_commit_ack(st_commit_ack),
    .flush_valid(flush_valid), .flush_pc(flush_pc),
    .rob_empty(rob_empty), .rob_count(rob_count)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy [DEPTH];
  bit          m_ready[DEPTH];
  bit          m_misp [DEPTH];
  int          m_type [DEPTH];
  int          m_rd   [DEPTH];
  logic [31:0] m_val  [DEPTH];
  logic [31:0] m_tgt  [DEPTH];
  int          m_head, m_tail, m_count, m_st_tag;
  bit          m_st_wait;
  bit          e_cv, e_fv;
  int          e_crd, e_ctag;
  logic [31:0] e_cval, e_fpc;

  task automatic m_reset;
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 0; m_ready[i] = 0;
    end
    m_head = 0; m_tail = 0; m_count = 0; m_st_wait = 0; m_st_tag = 0;
    e_cv = 0; e_fv = 0; e_crd = 0; e_ctag = 0; e_cval = 0; e_fpc = 0;
  endtask

  // inputs captured mid-cycle, consumed by the model at the next rising edge
  bit c_rst, c_rdy, c_av, c_ack;
  logic [1:0] c_at;
  logic [4:0] c_ard;
  logic [P-1:0] c_wbv, c_wbm;
  logic [P*TAG_W-1:0] c_wbt;
  logic [P*XLEN-1:0] c_wbval, c_wbtgt;

  task automatic model_step;
    bit old_busy[DEPTH];
    bit taken[DEPTH];
    bit retire, flush, do_alloc;
    int t;
    if (c_rst) begin m_reset(); return; end
    if (!c_rdy) begin e_cv = 0; e_fv = 0; return; end
    old_busy = m_busy;
    retire = 0; flush = 0; e_cv = 0; e_fv = 0;
    if (m_st_wait) begin
      if (c_ack) begin retire = 1; m_st_wait = 0; end
    end else if (m_busy[m_head] && m_ready[m_head]) begin
      if (m_type[m_head] == 1) begin
        m_st_wait = 1; m_st_tag = m_head;
      end else begin
        e_cv = 1; e_crd = m_rd[m_head]; e_cval = m_val[m_head]; e_ctag = m_head;
        retire = 1;
        if (m_type[m_head] >= 2 && m_misp[m_head]) begin
          flush = 1; e_fv = 1; e_fpc = m_tgt[m_head];
        end
      end
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
      m_head = 0; m_tail = 0; m_count = 0;
      return;
    end
    do_alloc = c_av && (m_count < DEPTH);
    for (int i = 0; i < DEPTH; i++) taken[i] = 0;
    for (int k = 0; k < P; k++) begin
      t = int'(c_wbt[k*TAG_W +: TAG_W]);
      if (c_wbv[k] && old_busy[t] && !taken[t]) begin
        taken[t] = 1; m_ready[t] = 1;
        m_val[t] = c_wbval[k*XLEN +: XLEN];
        m_tgt[t] = c_wbtgt[k*XLEN +: XLEN];
        m_misp[t] = c_wbm[k];
      end
    end
    if (retire) begin
      m_busy[m_head] = 0;
      m_head = (m_head + 1) % DEPTH;
    end
    if (do_alloc) begin
      m_busy[m_tail] = 1; m_ready[m_tail] = 0;
      m_type[m_tail] = int'(c_at); m_rd[m_tail] = int'(c_ard);
      m_tail = (m_tail + 1) % DEPTH;
    end
    m_count = m_count + int'(do_alloc) - int'(retire);
  endtask

  function automatic logic [32:0] m_lookup(input logic [TAG_W-1:0] tg);
    for (int k = 0; k < P; k++)
      if (wb_valid[k] && wb_tag[k*TAG_W +: TAG_W] == tg) return {1'b1, wb_value[k*XLEN +: XLEN]};
    if (m_ready[tg]) return {1'b1, m_val[tg]};
    return 33'd0;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [4:0]  log_rd [$];
  logic [31:0] log_val[$];
  int          log_cyc[$];

  initial begin
    m_reset();
    forever begin
      @(negedge clk_in);
      chk("commit_valid", commit_valid, e_cv);
      if (e_cv) begin
        chk("commit_rd", commit_rd, e_crd);
        chk("commit_value", commit_value, e_cval);
        chk("commit_tag", commit_tag, e_ctag);
      end
      chk("flush_valid", flush_valid, e_fv);
      if (e_fv) chk("flush_pc", flush_pc, e_fpc);
      chk("st_commit_valid", st_commit_valid, m_st_wait);
      if (m_st_wait) chk("st_commit_tag", st_commit_tag, m_st_tag);
      chk("rob_count", rob_count, m_count);
      chk("rob_empty", rob_empty, m_count == 0);
      chk("alloc_ready", alloc_ready, m_count < DEPTH);
      chk("alloc_tag", alloc_tag, m_tail);
      chk("q1_lookup", {q1_ready, q1_value}, m_lookup(q1_tag));
      chk("q2_lookup", {q2_ready, q2_value}, m_lookup(q2_tag));
      if (commit_valid) begin
        log_rd.push_back(commit_rd); log_val.push_back(commit_value); log_cyc.push_back(cyc);
      end
      c_rst = rst_in; c_rdy = rdy_in; c_av = alloc_valid; c_at = alloc_type; c_ard = alloc_rd;
      c_wbv = wb_valid; c_wbt = wb_tag; c_wbval = wb_value; c_wbtgt = wb_target;
      c_wbm = wb_mispredict; c_ack = st_commit_ack;
      @(posedge clk_in);
      cyc++;
      model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk_in); #2;
  endtask

  task automatic idle;
    rdy_in = 1; alloc_valid = 0; alloc_type = 0; alloc_rd = 0;
    wb_valid = 0; wb_tag = 0; wb_value = 0; wb_target = 0; wb_mispredict = 0;
    st_commit_ack = 0; q1_tag = 0; q2_tag = 0;
  endtask

  task automatic do_reset;
    rst_in = 1; idle(); tick(); tick(); rst_in = 0;
    log_rd.delete(); log_val.delete(); log_cyc.delete();
  endtask

  task automatic alloc_one(input logic [1:0] ty, input logic [4:0] rd);
    alloc_valid = 1; alloc_type = ty; alloc_rd = rd; tick(); alloc_valid = 0;
  endtask

  task automatic set_wb(input int p, input logic [TAG_W-1:0] tg, input logic [31:0] v,
                        input logic [31:0] tgt, input logic mp);
    wb_valid[p] = 1; wb_tag[p*TAG_W +: TAG_W] = tg;
    wb_value[p*XLEN +: XLEN] = v; wb_target[p*XLEN +: XLEN] = tgt; wb_mispredict[p] = mp;
  endtask

  task automatic clear_wb;
    wb_valid = 0; wb_mispredict = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bl[$];
    int n;
    rst_in = 1; idle();
    do_reset();
    #1;
    chk("reset_count", rob_count, 0);
    chk("reset_empty", rob_empty, 1);
    chk("reset_commit", commit_valid, 0);

    // fill and drain in order
    for (int i = 1; i <= 16; i++) alloc_one(2'd0, 5'(i));
    #1;
    chk("fill_alloc_ready", alloc_ready, 0);
    chk("fill_count", rob_count, 16);
    for (int i = 16; i >= 1; i--) begin
      set_wb(0, TAG_W'(i - 1), 32'(3 * i), 32'd0, 1'b0); tick(); clear_wb();
    end
    for (int w = 0; w < 40 && log_rd.size() < 16; w++) tick();
    chk("drain_commits", log_rd.size(), 16);
    n = log_rd.size();
    for (int i = 0; i < n; i++) begin
      chk("drain_rd", log_rd[i], i + 1);
      chk("drain_value", log_val[i], 3 * (i + 1));
      chk("drain_cycle", log_cyc[i], log_cyc[0] + i);
    end

    // dual write-back, same-tag conflict, forwarding
    do_reset();
    for (int i = 1; i <= 8; i++) alloc_one(2'd0, 5'(i));
    set_wb(0, 4'd2, 32'hAA, 32'd0, 1'b0); set_wb(1, 4'd5, 32'hBB, 32'd0, 1'b0);
    tick(); clear_wb();
    q1_tag = 4'd2; q2_tag = 4'd5; #1;
    chk("dual_q1_ready", q1_ready, 1); chk("dual_q1_value", q1_value, 32'hAA);
    chk("dual_q2_ready", q2_ready, 1); chk("dual_q2_value", q2_value, 32'hBB);
    set_wb(0, 4'd7, 32'h11, 32'd0, 1'b0); set_wb(1, 4'd7, 32'h22, 32'd0, 1'b0);
    q1_tag = 4'd7; #1;
    chk("conflict_fwd", q1_value, 32'h11);
    tick(); clear_wb(); #1;
    chk("conflict_kept", q1_value, 32'h11);
    q1_tag = 4'd3; #1;
    chk("fwd_before", {q1_ready, q1_value}, 33'd0);
    set_wb(1, 4'd3, 32'h1234, 32'd0, 1'b0); #1;
    chk("fwd_ready", q1_ready, 1); chk("fwd_value", q1_value, 32'h1234);
    tick(); clear_wb();

    // store handshake with ack delayed three cycles
    do_reset();
    alloc_one(2'd1, 5'd0);
    alloc_one(2'd0, 5'd9);
    set_wb(0, 4'd1, 32'h99, 32'd0, 1'b0); tick(); clear_wb();
    set_wb(0, 4'd0, 32'h5, 32'd0, 1'b0); tick(); clear_wb(); #1;
    chk("st_before", st_commit_valid, 0);
    for (int c = 0; c < 4; c++) begin
      tick(); #1;
      chk("st_level", st_commit_valid, 1);
      chk("st_younger_waits", commit_valid, 0);
    end
    chk("st_tag", st_commit_tag, 0);
    st_commit_ack = 1; tick(); st_commit_ack = 0; #1;
    chk("st_released", st_commit_valid, 0);
    chk("st_no_commit_yet", commit_valid, 0);
    tick(); #1;
    chk("st_next_commit", commit_valid, 1);
    chk("st_next_rd", commit_rd, 9);
    chk("st_next_value", commit_value, 32'h99);

    // mispredicted JALR flush
    do_reset();
    alloc_one(2'd0, 5'd1); alloc_one(2'd3, 5'd2); alloc_one(2'd0, 5'd3); alloc_one(2'd0, 5'd4);
    set_wb(0, 4'd0, 32'h10, 32'd0, 1'b0); set_wb(1, 4'd1, 32'h55, 32'h100, 1'b1);
    tick(); clear_wb();
    set_wb(0, 4'd2, 32'h30, 32'd0, 1'b0); set_wb(1, 4'd3, 32'h40, 32'd0, 1'b0);
    tick(); clear_wb(); #1;
    chk("misp_reg_commit", commit_valid, 1); chk("misp_reg_rd", commit_rd, 1);
    alloc_valid = 1; alloc_type = 2'd0; alloc_rd = 5'd7;
    set_wb(0, 4'd3, 32'h99, 32'd0, 1'b0);
    tick(); alloc_valid = 0; clear_wb(); #1;
    chk("flush_valid", flush_valid, 1); chk("flush_pc", flush_pc, 32'h100);
    chk("flush_link_rd", commit_rd, 2); chk("flush_link_val", commit_value, 32'h55);
    chk("flush_count", rob_count, 0); chk("flush_tail", alloc_tag, 0);
    tick(); #1;
    chk("flush_pulse", flush_valid, 0); chk("flush_no_commit", commit_valid, 0);

    // tail wrap, then reset while a store waits
    do_reset();
    for (int i = 0; i < 15; i++) begin
      alloc_one(2'd0, 5'(i + 1));
      set_wb(0, TAG_W'(i), 32'(i + 100), 32'd0, 1'b0); tick(); clear_wb();
    end
    tick(); tick(); tick(); #1;
    chk("wrap_tail15", alloc_tag, 15); chk("wrap_empty", rob_count, 0);
    alloc_one(2'd1, 5'd5); #1;
    chk("wrap_tail0", alloc_tag, 0);
    set_wb(0, 4'd15, 32'h5, 32'd0, 1'b0); tick(); clear_wb();
    tick(); #1;
    chk("wrap_st_wait", st_commit_valid, 1); chk("wrap_st_tag", st_commit_tag, 15);
    rst_in = 1; tick(); rst_in = 0; #1;
    chk("rst_st", st_commit_valid, 0); chk("rst_cv", commit_valid, 0);
    chk("rst_crd", commit_rd, 0); chk("rst_cval", commit_value, 0);
    chk("rst_ctag", commit_tag, 0); chk("rst_sttag", st_commit_tag, 0);
    chk("rst_fv", flush_valid, 0); chk("rst_fpc", flush_pc, 0);
    chk("rst_count", rob_count, 0); chk("rst_tail", alloc_tag, 0);

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst_in = ($urandom_range(0, 499) == 0);
      rdy_in = ($urandom_range(0, 9) != 0);
      alloc_valid = ($urandom_range(0, 9) < 6);
      alloc_type = 2'($urandom_range(0, 3));
      alloc_rd = 5'($urandom_range(0, 31));
      bl.delete();
      for (int i = 0; i < DEPTH; i++) if (m_busy[i]) bl.push_back(i);
      for (int k = 0; k < P; k++) begin
        wb_valid[k] = ($urandom_range(0, 1) == 1);
        if (bl.size() > 0 && $urandom_range(0, 9) < 8)
          wb_tag[k*TAG_W +: TAG_W] = TAG_W'(bl[$urandom_range(0, bl.size() - 1)]);
        else
          wb_tag[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, DEPTH - 1));
        wb_value[k*XLEN +: XLEN] = $urandom;
        wb_target[k*XLEN +: XLEN] = $urandom;
        wb_mispredict[k] = ($urandom_range(0, 99) < 4);
      end
      st_commit_ack = ($urandom_range(0, 1) == 1);
      q1_tag = TAG_W'($urandom_range(0, DEPTH - 1));
      q2_tag = TAG_W'($urandom_range(0, DEPTH - 1));
      tick();
    end
    rst_in = 0; idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/rob_multi_wb.md
# rob_multi_wb

Parametrised reorder buffer for the out-of-order RISC-V core. It sits between the decoder, the register file, the execution units and the LSU. It allocates in-order tags at the tail and accepts write-backs from `WB_PORTS` independent result buses. It forwards ready operand values to the decoder and retires one entry per cycle from the head. Retirement covers register commit, store release through a handshake with the LSU, and full flush on a mispredicted branch or JALR.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥4.
- `TAG_W`, 4: tag width, equal to log2(DEPTH).
- `XLEN`, 32: data and address width.
- `WB_PORTS`, 2: number of write-back channels; buses are flattened with port k at slice [k*W +: W].
- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_in`  in  1  reset, synchronous and active-high.
- `rdy_in`  in  1  global enable; when low, state is frozen.
- `alloc_valid`  in  1  decoder requests a new entry.
- `alloc_type`  in  2  entry type: 0 REG, 1 STORE, 2 BRANCH, 3 JALR.
- `alloc_rd`  in  5  destination register.
- `alloc_ready`  out  1  `count < DEPTH`.
- `alloc_tag`  out  TAG_W  tail index; the tag given to the entry allocated this cycle.
- `q1_tag`, `q2_tag`  in  TAG_W  operand lookup tags.
- `q1_ready`, `q2_ready`  out  1  looked-up value is available (combinational).
- `q1_value`, `q2_value`  out  XLEN  looked-up value; 0 when not ready.
- `wb_valid`  in  WB_PORTS  per-port result strobe.
- `wb_tag`  in  WB_PORTS*TAG_W  per-port target entry.
- `wb_value`  in  WB_PORTS*XLEN  per-port result or link value.
- `wb_target`  in  WB_PORTS*XLEN  per-port resolved next PC (BRANCH/JALR only).
- `wb_mispredict`  in  WB_PORTS  per-port flag: resolved PC differs from fetched path.
- `commit_valid`  out  1  one-cycle register commit pulse.
- `commit_rd`  out  5  register being committed.
- `commit_value`  out  XLEN  value being committed.
- `commit_tag`  out  TAG_W  tag being committed; lets the register file clear its rename.
- `st_commit_valid`  out  1  head STORE is released to the LSU (level).
- `st_commit_tag`  out  TAG_W  tag of the released STORE.
- `st_commit_ack`  in  1  LSU accepts the released STORE.
- `flush_valid`  out  1  one-cycle flush pulse.
- `flush_pc`  out  XLEN  redirect PC for the flush.
- `rob_empty`  out  1  `count == 0`.
- `rob_count`  out  TAG_W+1  number of occupied entries.

## Operation
- Each entry holds: busy, ready, type, rd, value, target, mispredict.
- head, tail and count reset to 0; all busy bits and all outputs reset to 0.
- Allocate when `alloc_valid && alloc_ready`:
  - entry[tail] becomes busy, not ready, with type and rd written.
  - tail advances by 1 and wraps modulo DEPTH.
- Write-back: for each port with `wb_valid`, entry[wb_tag] takes value, target and mispredict, and ready is set.
  - If two ports target the same tag, the lower-numbered port wins.
  - A write-back to a non-busy entry is ignored.
- Lookup:
  - `qN_ready` = entry[qN_tag].ready, or any `wb_valid` port with a matching tag in the same cycle (forward; lowest port wins).
  - `qN_value` comes from the same source.
- Retire, evaluated only when head is busy and ready. Head state machine IDLE / ST_WAIT:
  - REG: `commit_valid` pulses with rd, value and tag; head advances.
  - STORE: move to ST_WAIT; `st_commit_valid` = 1 until the cycle `st_commit_ack` is sampled high; the entry then retires and the state returns to IDLE. No other retire happens in ST_WAIT.
  - BRANCH / JALR with mispredict = 0: `commit_valid` pulses (link value to rd) and head advances.
  - BRANCH / JALR with mispredict = 1: `commit_valid` pulses for rd, and `flush_valid` pulses with `flush_pc` = target. On the same edge all busy bits clear and head = tail = count = 0.
- A commit with rd = 0 still pulses; the register file ignores x0.
- count is incremented on allocate and decremented on retire. A simultaneous allocate and retire leaves count unchanged.
- Flush has priority: a same-cycle allocate is dropped, and write-backs that cycle are discarded.
- `rst_in` has priority over everything. Reset mid-handshake abandons ST_WAIT without an ack.
- With `rdy_in` low:
  - entries, pointers and state hold.
  - `commit_valid` and `flush_valid` are driven to 0.
  - `st_commit_valid` holds its level.
  - an ack arriving while `rdy_in` is low is ignored.

## Timing
- Allocate at edge E: the entry is visible to lookup from cycle E+1.
- Write-back at edge E:
  - forwarded combinationally during the cycle before E.
  - retire is decided at edge E+1 at the earliest, so `commit_valid` is high during cycle E+1 to E+2.
- Retire throughput is 1 per cycle for non-store entries.
- STORE: `st_commit_valid` rises one cycle after the store becomes head-ready. The entry retires at the edge where ack is sampled, and the next entry can retire at the following edge.
- `alloc_ready` reflects the registered count only. At count = DEPTH an allocate is refused even when a retire happens the same cycle.
- Wrap-around: tail = DEPTH−1 followed by an allocate gives tail = 0. Tags are reused only after the entry has retired.

## Test plan
- Fill/drain: DEPTH=16, allocate 16 REG entries (rd 1..16) → `alloc_ready`=0, `rob_count`=16. Write back in reverse order with value = rd×3 → commits emerge in order rd 1..16 with values 3..48, one per cycle.
- Dual write-back: port0 and port1 both strobe in one cycle, tags 2 and 5 (values 0xAA and 0xBB) → both entries ready. A conflicting case where both ports target tag 7 → the port0 value is kept.
- Forwarding: query tag 3 in the same cycle port1 writes 0x1234 to tag 3 → `q1_ready`=1, `q1_value`=0x1234.
- Store handshake: STORE head-ready, ack held low for 3 cycles → `st_commit_valid` is high for 4 cycles and the younger REG entry waits. It commits 1 cycle after the ack.
- Mispredict flush: entries REG, JALR (target 0x100, mispredict), REG, REG → REG commit, then `flush_valid` with `flush_pc`=0x100. Afterwards `rob_count`=0 and `alloc_tag`=0, and a same-cycle allocate is dropped.
- Wrap and reset: advance tail to 15 and allocate → tail 0. Assert `rst_in` while in ST_WAIT → all outputs 0 on the next cycle.
